// File: rtl/wasca_input_pio_deb.sv
// Switch/button input PIO: synchronise, debounce per bit, capture edges into W1C flags, maskable level irq.
// Latency: deb updates SYNC_STAGES+DEBOUNCE_CYCLES edges after a new stable level; readdata one edge later.
module wasca_input_pio_deb #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] deb_q;
    logic [15:0]      cnt_q [WIDTH];
    logic [WIDTH-1:0] fire;
    logic [WIDTH-1:0] event_vec;
    logic [WIDTH-1:0] edge_cap_q;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] clr_vec;
    logic [31:0]      rd_nxt;
    logic             wr_mask;
    logic             wr_clr;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A bit is accepted on the cycle its counter has seen DEBOUNCE_CYCLES consecutive disagreements.
    always_comb begin
        fire = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fire[i] = (s[i] != deb_q[i]) && (cnt_q[i] == CNT_MAX);
        end
    end

    always_comb begin
        event_vec = '0;
        if (EDGE_MODE == 0)      event_vec = fire & s;
        else if (EDGE_MODE == 1) event_vec = fire & ~s;
        else                     event_vec = fire;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    deb_q[i] <= s[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign wr_mask = write && (address == 2'd1);
    assign wr_clr  = write && (address == 2'd3);
    assign clr_vec = wr_clr ? writedata[WIDTH-1:0] : '0;

    // New events are OR-ed in after the clear, so a coincident set wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap_q <= '0;
            irq_mask_q <= '0;
        end else begin
            edge_cap_q <= (edge_cap_q & ~clr_vec) | event_vec;
            if (wr_mask) irq_mask_q <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_nxt = '0;
        case (address)
            2'd0:    rd_nxt[WIDTH-1:0] = deb_q;
            2'd1:    rd_nxt[WIDTH-1:0] = irq_mask_q;
            2'd2:    rd_nxt[WIDTH-1:0] = s;
            default: rd_nxt[WIDTH-1:0] = edge_cap_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_nxt;
    end

    assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_wasca_input_pio_deb.sv
// Directed bench for wasca_input_pio_deb: one EDGE_MODE=2 instance and one EDGE_MODE=0 instance.
module tb_wasca_input_pio_deb;

    logic        clk = 1'b0;
    logic        reset_n, reset_n0;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata, readdata0;
    logic [7:0]  in_port, in_port0;
    logic        irq, irq0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    wasca_input_pio_deb #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write),
        .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
    );

    wasca_input_pio_deb #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0)) dut0 (
        .clk(clk), .reset_n(reset_n0), .address(address), .write(write),
        .writedata(writedata), .readdata(readdata0), .in_port(in_port0), .irq(irq0)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        tick(1);
        write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick(1);
    endtask

    initial begin
        reset_n = 1'b0; reset_n0 = 1'b0;
        in_port = 8'h00; in_port0 = 8'h00;
        address = 2'd0; write = 1'b0; writedata = 32'h0;
        tick(2);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1; reset_n0 = 1'b1;

        // Idle inputs
        for (int c = 0; c < 20; c++) begin
            tick(1);
            chk("idle_irq", {31'h0, irq}, 32'h0);
        end
        rd(2'd0); chk("idle_data", readdata, 32'h0);
        rd(2'd1); chk("idle_mask", readdata, 32'h0);
        rd(2'd3); chk("idle_edge", readdata, 32'h0);

        // Latency: RAW visible at edge 3, DATA at edge 7
        in_port = 8'hA5;
        address = 2'd2;
        tick(2); chk("raw_e2", readdata, 32'h0);
        tick(1); chk("raw_e3", readdata, 32'h0000_00A5);
        address = 2'd0;
        tick(3); chk("data_e6", readdata, 32'h0);
        tick(1); chk("data_e7", readdata, 32'h0000_00A5);
        chk("lat_irq_masked", {31'h0, irq}, 32'h0);
        in_port = 8'h00;
        tick(10);
        rd(2'd3); chk("lat_edges_both", readdata, 32'h0000_00A5);
        wr(2'd3, 32'hFF);
        rd(2'd3); chk("lat_edges_clr", readdata, 32'h0);

        // Glitch rejection: 3-cycle pulse filtered, 6-cycle pulse accepted
        in_port = 8'h01; tick(3); in_port = 8'h00;
        tick(10);
        rd(2'd0); chk("glitch_data", readdata, 32'h0);
        rd(2'd3); chk("glitch_edge", readdata, 32'h0);
        in_port = 8'h01; tick(6); in_port = 8'h00;
        rd(2'd0); chk("pulse6_data", readdata, 32'h0000_0001);
        tick(10);
        rd(2'd3); chk("pulse6_edge", readdata, 32'h0000_0001);
        wr(2'd3, 32'h1);

        // Interrupt
        wr(2'd1, 32'h1);
        in_port = 8'h01;
        tick(5); chk("irq_e5", {31'h0, irq}, 32'h0);
        tick(1); chk("irq_e6", {31'h0, irq}, 32'h1);
        wr(2'd3, 32'h1);
        chk("irq_w1c", {31'h0, irq}, 32'h0);
        rd(2'd3); chk("edge_after_w1c", readdata, 32'h0);
        in_port = 8'h00;
        tick(10);
        chk("irq_fall", {31'h0, irq}, 32'h1);
        wr(2'd1, 32'h0);
        chk("irq_unmasked", {31'h0, irq}, 32'h0);
        rd(2'd3); chk("edge_pending", readdata, 32'h0000_0001);
        wr(2'd3, 32'hFF);

        // Collision: W1C on the capturing edge of bit3
        wr(2'd1, 32'h08);
        in_port = 8'h08;
        tick(5); chk("coll_pre_irq", {31'h0, irq}, 32'h0);
        address = 2'd3; writedata = 32'h08; write = 1'b1;
        tick(1);
        write = 1'b0;
        chk("coll_irq", {31'h0, irq}, 32'h1);
        rd(2'd3); chk("coll_edge", readdata, 32'h0000_0008);
        in_port = 8'h00;
        tick(10);
        wr(2'd3, 32'hFF);
        wr(2'd1, 32'h0);

        // Same-cycle read/write shows pre-write value; upper bits read 0
        wr(2'd1, 32'hFFFF_FF5A);
        chk("rw_prewrite", readdata, 32'h0);
        rd(2'd1); chk("rw_postwrite", readdata, 32'h0000_005A);
        wr(2'd1, 32'h0);

        // EDGE_MODE=0 instance: falling ignored, rising captured
        in_port0 = 8'h80; tick(10);
        wr(2'd3, 32'hFF);
        rd(2'd3); chk("m0_cleared", readdata0, 32'h0);
        in_port0 = 8'h00; tick(10);
        rd(2'd3); chk("m0_fall", readdata0, 32'h0);
        in_port0 = 8'h80; tick(10);
        rd(2'd3); chk("m0_rise", readdata0, 32'h0000_0080);
        chk("m2_unaffected", readdata, 32'h0);
        in_port0 = 8'h00; tick(10);
        wr(2'd3, 32'hFF);

        // Reset mid-count, release with bit7 high
        in_port0 = 8'h80; tick(4);
        reset_n0 = 1'b0; tick(1);
        chk("m0_rst_rd", readdata0, 32'h0);
        chk("m0_rst_irq", {31'h0, irq0}, 32'h0);
        reset_n0 = 1'b1;
        wr(2'd1, 32'h80);
        tick(4); chk("m0_rel_e5", {31'h0, irq0}, 32'h0);
        tick(1); chk("m0_rel_e6", {31'h0, irq0}, 32'h1);
        rd(2'd3); chk("m0_rel_edge", readdata0, 32'h0000_0080);
        rd(2'd0); chk("m0_rel_data", readdata0, 32'h0000_0080);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
